pc_sequencer_ras: RTL
=====================

// Module: pc_sequencer_ras
// PURPOSE
//   Parametrised fetch-stage PC sequencer, successor to the single-width counter. It selects the next PC from
//   trap vector, branch target, jump target, return-address-stack (RAS) pop, hold (stall) or PC+STEP.
//   Jumps flagged as calls push PC+STEP onto an internal RAS of depth RAS_DEPTH. Sits between IF and ID/EX redirect logic.
// PARAMETERS
//   WIDTH      32  PC and target width, bits
//   STEP       1   increment per sequential fetch (1 = word-addressed)
//   RESET_VEC  0   PC value on reset
//   TRAP_VEC   4   PC value loaded on trap
//   RAS_DEPTH  4   return-address-stack entries, >=2
// PORTS
//   clk            in   1                      rising-edge clock
//   rst            in   1                      asynchronous, active-high reset
//   stall          in   1                      hold PC (suppresses increment only)
//   trap           in   1                      redirect to TRAP_VEC, flush RAS
//   select_branch  in   1                      take branch target
//   branch         in   WIDTH                  branch target
//   select_jump    in   1                      take jump target
//   jump           in   WIDTH                  jump target
//   call           in   1                      qualifies a taken jump as a call (push PC+STEP)
//   ret            in   1                      pop RAS into PC
//   pc             out  WIDTH                  current fetch PC
//   ras_count      out  $clog2(RAS_DEPTH+1)    valid RAS entries
//   ras_overflow   out  1                      sticky: push while full
//   ras_underflow  out  1                      sticky: pop while empty
// BEHAVIOUR
//   - rst=1 (async, immediate): pc=RESET_VEC, ras_count=0, TOS pointer=0, both flags=0. RAS contents don't-care.
//   - All other updates on rising clk; new pc visible one cycle after the request (single-cycle latency).
//   - Next-PC priority, highest first:
//       1. trap          -> TRAP_VEC; ras_count<=0; no push/pop
//       2. select_branch -> branch   (branch beats jump, as before)
//       3. select_jump   -> jump; if call: push pc+STEP
//       4. ret           -> pop: pc<=RAS[TOS] when ras_count>0
//       5. stall         -> pc held
//       6. otherwise     -> pc+STEP
//   - stall never blocks trap/branch/jump/ret; it only replaces the increment.
//   - call without taken jump (select_jump=0, or overridden by trap/branch): ignored, no push.
//   - ret overridden by a higher-priority source: ignored, no pop, no underflow.
//   - Arithmetic: pc+STEP computed modulo 2^WIDTH; 'hFF..F + 1 wraps to 0. Push value uses same wrap.
//   - RAS is circular: push writes RAS[(TOS+1)%RAS_DEPTH] and advances TOS; pop reads RAS[TOS], decrements TOS mod RAS_DEPTH.
//   - Push when ras_count==RAS_DEPTH: oldest entry overwritten, ras_count stays RAS_DEPTH, ras_overflow<=1.
//   - ret when ras_count==0: treated as no redirect (stall/increment rules apply), ras_underflow<=1, TOS unchanged.
//   - Flags are sticky and cleared only by rst. trap does not clear flags.
// TESTING
//   1. Hold rst=1 mid-run at pc=0x37 -> pc=RESET_VEC same cycle without clk edge; ras_count=0, flags 0.
//   2. WIDTH=8, STEP=1, pc=8'hFF, no requests -> next pc=8'h00; STEP=4, pc=8'hFE -> 8'h02.
//   3. select_branch=1 branch=0x40, select_jump=1 jump=0x80 call=1 -> pc=0x40, ras_count stays 0.
//   4. pc=0x10, select_jump=1 jump=0x100 call=1 -> pc=0x100, ras_count=1; then ret -> pc=0x11, ras_count=0.
//   5. RAS_DEPTH=4: five calls from pc 0x10,0x20,..,0x50 -> ras_overflow=1, count 4; four rets -> 0x51,0x41,0x31,0x21;
//      fifth ret at pc=P -> pc=P+1, ras_underflow=1.
//   6. stall=1 for 3 cycles -> pc constant; stall=1 with select_branch=1 branch=0x200 -> pc=0x200; trap with stall -> TRAP_VEC, count 0.

Source files
------------

// File: rtl/pc_sequencer_ras_if.sv
// Fetch-PC sequencer request/response bundle: redirect requests in, fetch PC and RAS status out.
interface pc_sequencer_ras_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic             stall;
  logic             trap;
  logic             select_branch;
  logic [WIDTH-1:0] branch;
  logic             select_jump;
  logic [WIDTH-1:0] jump;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc;
  logic [CW-1:0]    ras_count;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output stall, trap, select_branch, branch, select_jump, jump, call, ret,
    input  pc, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, trap, select_branch, branch, select_jump, jump, call, ret,
    output pc, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer_ras.sv
// Fetch-stage PC sequencer: trap/branch/jump/return/stall/increment selection with a
// circular return-address stack fed by calls.
module pc_sequencer_ras #(
  parameter int          WIDTH     = 32,
  parameter int          STEP      = 1,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned TRAP_VEC  = 4,
  parameter int          RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  pc_sequencer_ras_if.slave  bus
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] pc_reg, pc_next, pc_inc;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    tos_reg, tos_next, tos_inc, tos_dec;
  logic [CW-1:0]    count_reg, count_next;
  logic             overflow_reg, underflow_reg;
  logic             push, pop_req, pop, ras_full, ras_empty;

  assign ras_full  = (count_reg == CW'(RAS_DEPTH));
  assign ras_empty = (count_reg == '0);
  assign tos_inc   = (tos_reg == PW'(RAS_DEPTH - 1)) ? '0 : tos_reg + PW'(1);
  assign tos_dec   = (tos_reg == '0) ? PW'(RAS_DEPTH - 1) : tos_reg - PW'(1);
  assign pc_inc    = pc_reg + WIDTH'(STEP);

  // A call or return only takes effect when nothing of higher priority redirects.
  assign push    = !bus.trap && !bus.select_branch && bus.select_jump && bus.call;
  assign pop_req = !bus.trap && !bus.select_branch && !bus.select_jump && bus.ret;
  assign pop     = pop_req && !ras_empty;

  always_comb begin
    pc_next    = pc_inc;
    tos_next   = tos_reg;
    count_next = count_reg;
    if (bus.trap) begin
      pc_next    = WIDTH'(TRAP_VEC);
      count_next = '0;
    end else if (bus.select_branch) begin
      pc_next = bus.branch;
    end else if (bus.select_jump) begin
      pc_next = bus.jump;
      if (push) begin
        tos_next = tos_inc;
        if (!ras_full) count_next = count_reg + CW'(1);
      end
    end else if (pop) begin
      pc_next    = ras_mem[tos_reg];
      tos_next   = tos_dec;
      count_next = count_reg - CW'(1);
    end else if (bus.stall) begin
      pc_next = pc_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg        <= WIDTH'(RESET_VEC);
      tos_reg       <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      tos_reg       <= tos_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_reg | (push & ras_full);
      underflow_reg <= underflow_reg | (pop_req & ras_empty);
    end
  end

  // Stack storage carries no reset; a full push simply overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (push) ras_mem[tos_inc] <= pc_inc;
  end

  assign bus.pc            = pc_reg;
  assign bus.ras_count     = count_reg;
  assign bus.ras_overflow  = overflow_reg;
  assign bus.ras_underflow = underflow_reg;
endmodule
